// File: rtl/tag_free_alloc.sv
// tag_free_alloc: 32-entry tag allocator; free bitmap feeds a registered highest-index-wins pick.
// Optional same-cycle free-to-grant bypass enabled by defining TAG_FREE_ALLOC_BYPASS_EN.
module tag_free_alloc #(
    parameter logic [31:0] RESV_MASK = 32'h0000_0000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       alloc_req,
    output logic       alloc_gnt,
    output logic [4:0] alloc_tag,
    input  logic       free_valid,
    input  logic [4:0] free_tag,
    output logic       empty,
    output logic [5:0] free_cnt,
    output logic       dbl_free_err
);

    function automatic logic [4:0] f_prio(input logic [31:0] m);
        f_prio = 5'd0;
        for (int i = 0; i < 32; i++) begin
            if (m[i]) f_prio = 5'(i);
        end
    endfunction

    function automatic logic [5:0] f_pop(input logic [31:0] m);
        f_pop = 6'd0;
        for (int i = 0; i < 32; i++) begin
            f_pop = f_pop + 6'(m[i]);
        end
    endfunction

    localparam logic [31:0] L_RST_MAP = ~RESV_MASK;
    localparam logic [4:0]  L_RST_TAG = f_prio(L_RST_MAP);
    localparam logic [5:0]  L_RST_CNT = f_pop(L_RST_MAP);
    localparam logic        L_RST_VLD = (L_RST_MAP != 32'h0);

    logic [31:0] r_free_map;
    logic [4:0]  r_next_tag;
    logic        r_next_vld;
    logic [5:0]  r_free_cnt;
    logic        r_err;

    logic        w_legal;
    logic        w_take;
    logic        w_byp;
    logic        w_set;
    logic [31:0] w_map_n;
    logic [5:0]  w_cnt_n;

    // A free is legal only for a tag that is currently out and not reserved.
    assign w_legal = free_valid & ~r_free_map[free_tag] & ~RESV_MASK[free_tag];
    assign w_take  = alloc_req & r_next_vld;

`ifdef TAG_FREE_ALLOC_BYPASS_EN
    assign w_byp = alloc_req & ~r_next_vld & w_legal;
`else
    assign w_byp = 1'b0;
`endif

    // A bypassed tag goes straight back out, so it never lands in the map.
    assign w_set     = w_legal & ~w_byp;
    assign alloc_gnt = w_take | w_byp;
    assign alloc_tag = w_byp ? free_tag : r_next_tag;
    assign empty     = ~r_next_vld;
    assign free_cnt  = r_free_cnt;
    assign dbl_free_err = r_err;

    always_comb begin
        w_map_n = r_free_map;
        if (w_take) w_map_n[r_next_tag] = 1'b0;
        if (w_set)  w_map_n[free_tag]   = 1'b1;
        w_cnt_n = r_free_cnt - {5'd0, w_take} + {5'd0, w_set};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_free_map <= L_RST_MAP;
            r_next_tag <= L_RST_TAG;
            r_next_vld <= L_RST_VLD;
            r_free_cnt <= L_RST_CNT;
            r_err      <= 1'b0;
        end else begin
            r_free_map <= w_map_n;
            r_next_tag <= f_prio(w_map_n);
            r_next_vld <= |w_map_n;
            r_free_cnt <= w_cnt_n;
            r_err      <= r_err | (free_valid & ~w_legal);
        end
    end

endmodule

// File: tb/tb_tag_free_alloc.sv
// tb_tag_free_alloc: directed vectors for the tag allocator.
// Two instances: no reserved tags, and tags 0 and 31 reserved.
module tb_tag_free_alloc;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       a_req, a_gnt, a_fv, a_empty, a_err;
    logic [4:0] a_tag, a_ft;
    logic [5:0] a_cnt;
    logic       b_req, b_gnt, b_fv, b_empty, b_err;
    logic [4:0] b_tag, b_ft;
    logic [5:0] b_cnt;

    int n_run  = 0;
    int n_fail = 0;

    tag_free_alloc #(.RESV_MASK(32'h0000_0000)) u_a (
        .clk(clk), .rst_n(rst_n),
        .alloc_req(a_req), .alloc_gnt(a_gnt), .alloc_tag(a_tag),
        .free_valid(a_fv), .free_tag(a_ft),
        .empty(a_empty), .free_cnt(a_cnt), .dbl_free_err(a_err)
    );

    tag_free_alloc #(.RESV_MASK(32'h8000_0001)) u_b (
        .clk(clk), .rst_n(rst_n),
        .alloc_req(b_req), .alloc_gnt(b_gnt), .alloc_tag(b_tag),
        .free_valid(b_fv), .free_tag(b_ft),
        .empty(b_empty), .free_cnt(b_cnt), .dbl_free_err(b_err)
    );

    typedef struct {
        logic       req;
        logic       fv;
        logic [4:0] ft;
        logic       gnt;
        logic [4:0] tag;
        logic [5:0] cnt;
        logic       err;
    } vec_t;

    vec_t tv[13];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic drv_a(input logic rq, input logic fv, input logic [4:0] ft);
        @(negedge clk);
        a_req = rq; a_fv = fv; a_ft = ft;
        #1;
    endtask

    task automatic drv_b(input logic rq, input logic fv, input logic [4:0] ft);
        @(negedge clk);
        b_req = rq; b_fv = fv; b_ft = ft;
        #1;
    endtask

    initial begin
        // {req, fv, ft, gnt, tag, cnt, err}; outputs sampled before the edge
        tv[0]  = '{1'b1, 1'b0, 5'd0,  1'b1, 5'd31, 6'd32, 1'b0};
        tv[1]  = '{1'b1, 1'b0, 5'd0,  1'b1, 5'd30, 6'd31, 1'b0};
        tv[2]  = '{1'b1, 1'b0, 5'd0,  1'b1, 5'd29, 6'd30, 1'b0};
        tv[3]  = '{1'b0, 1'b0, 5'd0,  1'b0, 5'd28, 6'd29, 1'b0};
        tv[4]  = '{1'b1, 1'b1, 5'd31, 1'b1, 5'd28, 6'd29, 1'b0};
        tv[5]  = '{1'b0, 1'b0, 5'd0,  1'b0, 5'd31, 6'd29, 1'b0};
        tv[6]  = '{1'b1, 1'b0, 5'd0,  1'b1, 5'd31, 6'd29, 1'b0};
        tv[7]  = '{1'b0, 1'b1, 5'd5,  1'b0, 5'd27, 6'd28, 1'b0};
        tv[8]  = '{1'b0, 1'b0, 5'd0,  1'b0, 5'd27, 6'd28, 1'b1};
        tv[9]  = '{1'b0, 1'b1, 5'd30, 1'b0, 5'd27, 6'd28, 1'b1};
        tv[10] = '{1'b0, 1'b0, 5'd0,  1'b0, 5'd30, 6'd29, 1'b1};
        tv[11] = '{1'b1, 1'b1, 5'd30, 1'b1, 5'd30, 6'd29, 1'b1};
        tv[12] = '{1'b0, 1'b0, 5'd0,  1'b0, 5'd27, 6'd28, 1'b1};

        rst_n = 1'b0;
        a_req = 1'b0; a_fv = 1'b0; a_ft = 5'd0;
        b_req = 1'b0; b_fv = 1'b0; b_ft = 5'd0;
        #12;
        chk("rst_a_cnt", a_cnt, 32);
        chk("rst_a_tag", a_tag, 31);
        chk("rst_a_empty", a_empty, 0);
        chk("rst_a_gnt", a_gnt, 0);
        chk("rst_a_err", a_err, 0);
        chk("rst_b_cnt", b_cnt, 30);
        chk("rst_b_tag", b_tag, 30);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 13; i++) begin
            drv_a(tv[i].req, tv[i].fv, tv[i].ft);
            chk($sformatf("v%0d_gnt", i), a_gnt, tv[i].gnt);
            chk($sformatf("v%0d_tag", i), a_tag, tv[i].tag);
            chk($sformatf("v%0d_cnt", i), a_cnt, tv[i].cnt);
            chk($sformatf("v%0d_err", i), a_err, tv[i].err);
            chk($sformatf("v%0d_empty", i), a_empty, 0);
        end

        // Drain the remaining 28 tags: highest index first
        for (int t = 27; t >= 0; t--) begin
            drv_a(1'b1, 1'b0, 5'd0);
            chk($sformatf("drain_gnt_%0d", t), a_gnt, 1);
            chk($sformatf("drain_tag_%0d", t), a_tag, t);
        end
        drv_a(1'b1, 1'b0, 5'd0);
        chk("empty_gnt", a_gnt, 0);
        chk("empty_flag", a_empty, 1);
        chk("empty_cnt", a_cnt, 0);

        drv_a(1'b1, 1'b1, 5'd7);
`ifdef TAG_FREE_ALLOC_BYPASS_EN
        chk("byp_gnt", a_gnt, 1);
        chk("byp_tag", a_tag, 7);
        drv_a(1'b1, 1'b0, 5'd0);
        chk("byp_after_gnt", a_gnt, 0);
        chk("byp_after_empty", a_empty, 1);
        chk("byp_after_cnt", a_cnt, 0);
`else
        chk("free7_gnt_same", a_gnt, 0);
        drv_a(1'b1, 1'b0, 5'd0);
        chk("free7_gnt_next", a_gnt, 1);
        chk("free7_tag_next", a_tag, 7);
        chk("free7_cnt_next", a_cnt, 1);
`endif
        drv_a(1'b0, 1'b0, 5'd0);
        chk("refill_cnt", a_cnt, 0);
        chk("refill_empty", a_empty, 1);

        // Fresh start, 10 tags out, then asynchronous reset mid-cycle
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            drv_a(1'b1, 1'b0, 5'd0);
            chk($sformatf("out10_tag_%0d", k), a_tag, 31 - k);
        end
        drv_a(1'b0, 1'b1, 5'd0);
        drv_a(1'b0, 1'b0, 5'd0);
        chk("pre_rst_err", a_err, 1);
        chk("pre_rst_cnt", a_cnt, 22);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_cnt", a_cnt, 32);
        chk("async_rst_tag", a_tag, 31);
        chk("async_rst_err", a_err, 0);
        chk("async_rst_empty", a_empty, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Reserved tags 0 and 31 are never handed out
        for (int t = 30; t >= 1; t--) begin
            drv_b(1'b1, 1'b0, 5'd0);
            chk($sformatf("resv_gnt_%0d", t), b_gnt, 1);
            chk($sformatf("resv_tag_%0d", t), b_tag, t);
        end
        drv_b(1'b1, 1'b0, 5'd0);
        chk("resv_empty_gnt", b_gnt, 0);
        chk("resv_empty", b_empty, 1);
        chk("resv_empty_cnt", b_cnt, 0);
        drv_b(1'b0, 1'b1, 5'd31);
        chk("resv_err_before", b_err, 0);
        drv_b(1'b0, 1'b0, 5'd0);
        chk("resv_err_after", b_err, 1);
        chk("resv_cnt_after", b_cnt, 0);
        chk("resv_empty_after", b_empty, 1);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/tag_free_alloc.md
Name: tag_free_alloc

Overview:
- 32-entry tag allocator (e.g. ROB/load-buffer tags); upstream/downstream partner of the team's 32-to-5 priority encoder.
- Holds the free bitmap, drives it into a 32-to-5 highest-index-wins priority encoder, and registers the encoded result as the next tag to hand out.
- Consumers request tags with a req/gnt handshake; retiring logic returns tags through a free port.

Parameters:
- RESV_MASK, 32'h0000_0000, bits set = tags permanently reserved; never allocated, never set in the free map.

Ports:
- clk, input, 1, sole clock; all state updates on rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- alloc_req, input, 1, consumer requests one tag this cycle.
- alloc_gnt, output, 1, tag granted this cycle (combinational from state and inputs).
- alloc_tag, output, 5, granted tag; valid when alloc_gnt=1.
- free_valid, input, 1, return one tag this cycle.
- free_tag, input, 5, tag being returned.
- empty, output, 1, no allocatable tag held (next_vld=0).
- free_cnt, output, 6, number of free tags, 0..32.
- dbl_free_err, output, 1, sticky: illegal free seen.

Behaviour:
- State: free_map[31:0], next_tag[4:0], next_vld, free_cnt[5:0], dbl_free_err.
- Reset (async, rst_n=0):
  - free_map = ~RESV_MASK.
  - free_cnt = 32 - popcount(RESV_MASK).
  - next_tag = highest index set in ~RESV_MASK; next_vld = (~RESV_MASK != 0).
  - dbl_free_err = 0.
  - Outputs follow from this state: alloc_gnt=0 while alloc_req=0; empty=~next_vld.
- Grant (zero-latency):
  - alloc_gnt = alloc_req & next_vld.
  - alloc_tag = next_tag.
  - At most one grant per cycle.
- Free is legal only if free_map[free_tag]=0 and RESV_MASK[free_tag]=0. Otherwise:
  - dbl_free_err sets at the edge and holds until reset.
  - The map is not modified.
  - free_cnt is not incremented.
- Next-state map: map_n = (free_map & ~onehot(alloc_tag if gnt)) | onehot(free_tag if legal free).
- next_tag/next_vld are registered: each edge, next_tag <= priority-encode(map_n), next_vld <= |map_n. The grant of cycle N is never re-offered in cycle N+1.
- free_cnt <= free_cnt - gnt + legal_free. Simultaneous grant and legal free leaves the count unchanged.
- Boundary cases:
  - Same-cycle free and grant of different tags: both applied.
  - Free of the tag being granted in the same cycle: double free (map bit still 1 at that edge) → error; the grant proceeds.
  - Empty + alloc_req: alloc_gnt=0, no state change. The requester must hold alloc_req; no queuing.
  - Full (all non-reserved tags free) + legal free is impossible; any free in that state is flagged.
  - free_cnt saturation is impossible by construction.
  - rst_n asserted mid-operation: all outstanding tags are discarded immediately; the map returns to its reset value.
- next_tag always equals priority-encode(free_map) after any edge. The bench checks this invariant.

Optional Feature:
- Macro TAG_FREE_ALLOC_BYPASS_EN.
- Defined:
  - When next_vld=0 and a legal free arrives, alloc_gnt = alloc_req, and alloc_tag = free_tag in the same cycle.
  - If granted, the bit is not set in the map and free_cnt is unchanged.
  - If not granted, normal free behaviour applies.
- Undefined: no bypass; the freed tag becomes grantable one cycle later via next_tag.

Test Plan:
- Reset with RESV_MASK=0: alloc_req held 3 cycles → alloc_tag 31, 30, 29 with gnt=1 each cycle; free_cnt 32→29.
- Drain all 32 tags → empty=1, free_cnt=0, alloc_gnt=0. Free tag 7 → next cycle gnt=1, alloc_tag=7. With BYPASS_EN: gnt=1, tag 7 in the free cycle; free_cnt stays 0.
- After allocating 31 and 30, same cycle: alloc_req=1 plus free_tag=31 → alloc_tag=29; next alloc_tag=31; free_cnt unchanged across that cycle.
- free_tag=5 while tag 5 is still free → dbl_free_err=1 and sticky; map and free_cnt unchanged.
- RESV_MASK=32'h8000_0001: reset free_cnt=30, first alloc_tag=30. Draining gives 30 tags and never 0 or 31. Freeing 31 → dbl_free_err=1.
- Assert rst_n=0 mid-stream with 10 tags outstanding → async return to free_cnt=32, next_tag=31, err=0.
